acq_seq_ctrl: RTL and testbench
===============================

# acq_seq_ctrl

Multi-channel acquisition sequencer: arms on command, waits for a selectable trigger, then forwards a programmed number of post-trigger samples from `NUM_CH` parallel channels to a ready/valid output. Sits between the ADC sample front-end and the capture buffer/DMA. It is the parametrised successor of the single-channel acquisition controller, adding channel count, data width, trigger modes, backpressure and overflow reporting.

## Interface
- `NUM_CH`, 4, number of parallel channels (1..16)
- `DATA_W`, 12, bits per channel sample
- `CNT_W`, 16, width of post-trigger length counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `arm`  in  1  pulse; start a new acquisition
- `abort`  in  1  pulse; cancel any acquisition
- `trig_mode`  in  2  00 external, 01 level, 10 immediate, 11 reserved (never triggers)
- `trig_ext`  in  1  external trigger, level-sampled
- `trig_ch`  in  $clog2(NUM_CH) (min 1)  channel compared in level mode
- `trig_level`  in  DATA_W  unsigned threshold
- `post_len`  in  CNT_W  samples to capture; 0 means 1
- `smp_valid`  in  1  input sample strobe
- `smp_data`  in  NUM_CH*DATA_W  channel 0 in LSBs
- `out_valid`  out  1  output sample valid
- `out_data`  out  NUM_CH*DATA_W  captured sample
- `out_last`  out  1  final sample of acquisition
- `out_ready`  in  1  downstream accept
- `busy`  out  1  state is ARMED or CAPTURE
- `done`  out  1  state is DONE
- `overflow`  out  1  sticky; a sample was dropped
- `trig_tstamp`  out  32  timestamp of trigger (see Configuration)

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset → IDLE.
- IDLE/DONE + `arm` → ARMED; latches `trig_mode`, `trig_ch`, `trig_level`, `post_len`; clears `overflow`, sample counter.
- `arm` in ARMED/CAPTURE ignored. `abort` in any state → IDLE, clears `out_valid`; `abort` wins over simultaneous `arm`.
- Trigger evaluated only on `smp_valid` cycles in ARMED: external = `trig_ext` high same cycle; level = selected channel ≥ `trig_level`; immediate = first `smp_valid`. Trigger sample is captured sample #1; state → CAPTURE (or DONE-pending if length 1).
- Each captured sample increments counter (CNT_W bits); sample number `post_len` (latched) is last; `out_last` set with it. Counter never wraps: post_len=2^CNT_W−1 max.
- Output register: sample loaded when `!out_valid || out_ready`. If `out_valid && !out_ready` on a capture cycle → sample dropped, still counted, `overflow` set (sticky until next `arm`/reset).
- After last sample counted → DONE, regardless of whether it was dropped. Output register keeps draining in DONE; `done` asserts when state is DONE.
- `out_valid` clears on handshake unless reloaded same cycle.

## Timing
- Reset values: `out_valid`, `out_last`, `busy`, `done`, `overflow` = 0; `out_data`, `trig_tstamp` = 0.
- `arm` at cycle n → `busy`=1 at n+1.
- Capture latency: `smp_valid` at cycle n → `out_valid`/`out_data` at n+1.
- Last sample at n → `done`=1, `busy`=0 at n+1.
- `abort` at n → all state outputs idle at n+1 (`overflow` retained).
- Throughput: one sample per cycle with `out_ready` held high.

## Configuration
- `ACQ_SEQ_TSTAMP_EN` defined: free-running 32-bit counter from reset, wraps 2^32−1→0; value at trigger cycle latched into `trig_tstamp`, held until next trigger; cleared only by reset.
- Undefined: counter not built, `trig_tstamp` tied to 0.

## Test plan
- Immediate mode, post_len=4, continuous `smp_valid`, data 0x10..0x13 per channel, `out_ready`=1 → four outputs one cycle after each input, `out_last` on 4th, `done`=1 next cycle.
- Level mode, trig_ch=2, trig_level=0x800, ch2 ramps 0x7FE,0x7FF,0x800 → first output is 0x800 sample; earlier samples never appear.
- External mode, post_len=0 → exactly one sample output with `out_last`=1; `trig_ext` outside `smp_valid` cycles ignored.
- post_len=3, `out_ready`=0 throughout → one output held, `overflow`=1, state DONE after 3rd sample; re-arm clears `overflow`.
- `abort` in CAPTURE after 2 of 8 samples with simultaneous `arm` → IDLE next cycle, `out_valid`=0, `busy`=0; `rst` mid-capture → all outputs 0 immediately.
- With `ACQ_SEQ_TSTAMP_EN`, trigger 100 cycles after reset release → `trig_tstamp`=100±latency consistent with counter; without macro → 0.

Source files
------------

// File: rtl/acq_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acq_seq_ctrl - multi-channel acquisition sequencer
//
// Arms on command, waits for a selectable trigger, then forwards a programmed
// number of post-trigger samples (all NUM_CH channels in parallel) to a
// ready/valid output register. Samples that arrive while the output register
// is stalled are dropped but still counted, and the sticky overflow flag is
// set.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   arm, abort          start / cancel an acquisition (pulses)
//   trig_mode           00 external, 01 level, 10 immediate, 11 never
//   trig_ext            external trigger, sampled on smp_valid cycles
//   trig_ch, trig_level channel and unsigned threshold for level mode
//   post_len            samples to capture (0 is treated as 1)
//   smp_valid, smp_data input samples, channel 0 in the LSBs
//   out_valid/out_data/out_last/out_ready  captured sample stream
//   busy, done          ARMED|CAPTURE, DONE status
//   overflow            sticky dropped-sample flag, cleared by arm
//   trig_tstamp         free-running timestamp at the trigger cycle
//
// Optional feature macro: ACQ_SEQ_TSTAMP_EN builds the 32-bit timestamp
// counter; without it trig_tstamp is tied to zero.
// ---------------------------------------------------------------------------
module acq_seq_ctrl #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 12,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [1:0]               trig_mode,
    input  logic                     trig_ext,
    input  logic [CH_W-1:0]          trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic [CNT_W-1:0]         post_len,
    input  logic                     smp_valid,
    input  logic [NUM_CH*DATA_W-1:0] smp_data,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [31:0]              trig_tstamp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic [CH_W-1:0]            ch_q, ch_d;
    logic [DATA_W-1:0]          level_q, level_d;
    logic [CNT_W-1:0]           len_q, len_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       oval_q, oval_d;
    logic                       olast_q, olast_d;
    logic [NUM_CH*DATA_W-1:0]   odata_q, odata_d;
    logic                       ovf_q, ovf_d;

    logic [DATA_W-1:0]          sel_smp;
    logic                       trig_hit;
    logic                       trig_fire;
    logic                       cap;
    logic                       is_last;
    logic [CNT_W-1:0]           len_eff;
    logic [CNT_W-1:0]           cnt_inc;

    // Channel mux for level mode; out-of-range trig_ch reads as zero.
    always_comb begin
        sel_smp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_q) == i) sel_smp = smp_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        case (mode_q)
            2'b00:   trig_hit = trig_ext;
            2'b01:   trig_hit = (sel_smp >= level_q);
            2'b10:   trig_hit = 1'b1;
            default: trig_hit = 1'b0;
        endcase
    end

    assign trig_fire = (state_q == S_ARMED) && smp_valid && trig_hit;
    // The trigger sample itself is capture #1.
    assign cap       = trig_fire || ((state_q == S_CAPTURE) && smp_valid);
    assign len_eff   = (len_q == '0) ? CNT_W'(1) : len_q;
    // cnt_q < len_eff always holds while capturing, so this cannot wrap.
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign is_last   = (cnt_inc == len_eff);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ch_d    = ch_q;
        level_d = level_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        oval_d  = oval_q;
        olast_d = olast_q;
        odata_d = odata_q;
        ovf_d   = ovf_q;

        // Output register drains in every state.
        if (oval_q && out_ready) begin
            oval_d  = 1'b0;
            olast_d = 1'b0;
        end

        if (cap) begin
            cnt_d   = cnt_inc;
            state_d = is_last ? S_DONE : S_CAPTURE;
            if (!oval_q || out_ready) begin
                oval_d  = 1'b1;
                olast_d = is_last;
                odata_d = smp_data;
            end else begin
                ovf_d   = 1'b1;
            end
        end

        if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_ARMED;
            mode_d  = trig_mode;
            ch_d    = trig_ch;
            level_d = trig_level;
            len_d   = post_len;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        // Abort overrides everything above but leaves overflow visible.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            oval_d  = 1'b0;
            olast_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            ch_q    <= '0;
            level_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            oval_q  <= 1'b0;
            olast_q <= 1'b0;
            odata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            level_q <= level_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            oval_q  <= oval_d;
            olast_q <= olast_d;
            odata_q <= odata_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ACQ_SEQ_TSTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] tstamp_q, tstamp_d;

    always_comb begin
        ts_cnt_d = ts_cnt_q + 32'd1;
        tstamp_d = trig_fire ? ts_cnt_q : tstamp_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt_q <= '0;
            tstamp_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            tstamp_q <= tstamp_d;
        end
    end

    assign trig_tstamp = tstamp_q;
`else
    assign trig_tstamp = '0;
`endif

    assign out_valid = oval_q;
    assign out_last  = olast_q;
    assign out_data  = odata_q;
    assign busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// Directed bench for acq_seq_ctrl (NUM_CH=4, DATA_W=12, CNT_W=16).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the result of that edge.
module tb_acq_seq_ctrl;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int CNT_W  = 16;
    localparam int DW     = NUM_CH*DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm, abort;
    logic [1:0]        trig_mode;
    logic              trig_ext;
    logic [1:0]        trig_ch;
    logic [DATA_W-1:0] trig_level;
    logic [CNT_W-1:0]  post_len;
    logic              smp_valid;
    logic [DW-1:0]     smp_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy, done, overflow;
    logic [31:0]       trig_tstamp;

    int total = 0;
    int bad   = 0;

    acq_seq_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_ext(trig_ext), .trig_ch(trig_ch),
        .trig_level(trig_level), .post_len(post_len),
        .smp_valid(smp_valid), .smp_data(smp_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done),
        .overflow(overflow), .trig_tstamp(trig_tstamp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input logic [11:0] c3, input logic [11:0] c2,
                                          input logic [11:0] c1, input logic [11:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [DW-1:0] rep(input logic [11:0] v);
        return {v, v, v, v};
    endfunction

    logic [31:0] exp_ts;

    initial begin
`ifdef ACQ_SEQ_TSTAMP_EN
        exp_ts = 32'd100;
`else
        exp_ts = 32'd0;
`endif
        rst = 1'b1; arm = 0; abort = 0; trig_mode = 2'b00; trig_ext = 0;
        trig_ch = 0; trig_level = 0; post_len = 0; smp_valid = 0;
        smp_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_tstamp",    64'(trig_tstamp), 64'd0);
        rst = 1'b0;

        // ---- immediate mode, post_len=4, trigger 100 cycles after release
        trig_mode = 2'b10; post_len = 16'd4; arm = 1;
        tick();
        arm = 0;
        chk("imm_busy_after_arm", 64'(busy), 64'd1);
        chk("imm_done_after_arm", 64'(done), 64'd0);
        repeat (99) tick();
        for (int k = 0; k < 4; k++) begin
            smp_valid = 1; smp_data = rep(12'h010 + 12'(k));
            tick();
            chk("imm_out_valid", 64'(out_valid), 64'd1);
            chk("imm_out_data",  64'(out_data),  64'(rep(12'h010 + 12'(k))));
            chk("imm_out_last",  64'(out_last),  64'(k == 3));
            if (k == 0) chk("imm_tstamp", 64'(trig_tstamp), 64'(exp_ts));
        end
        chk("imm_done", 64'(done), 64'd1);
        chk("imm_busy", 64'(busy), 64'd0);
        smp_valid = 0;
        tick();
        chk("imm_drained", 64'(out_valid), 64'd0);
        chk("imm_tstamp_held", 64'(trig_tstamp), 64'(exp_ts));

        // ---- level mode, ch2 >= 0x800, post_len=2
        trig_mode = 2'b01; trig_ch = 2'd2; trig_level = 12'h800; post_len = 16'd2;
        arm = 1;
        tick();
        arm = 0;
        chk("lvl_busy", 64'(busy), 64'd1);
        smp_valid = 1; smp_data = pk(12'hFFF, 12'h7FE, 12'h900, 12'h000);
        tick();
        chk("lvl_no_out_7fe", 64'(out_valid), 64'd0);
        smp_data = pk(12'hFFF, 12'h7FF, 12'h900, 12'h001);
        tick();
        chk("lvl_no_out_7ff", 64'(out_valid), 64'd0);
        smp_data = pk(12'hFFF, 12'h800, 12'h900, 12'h002);
        tick();
        chk("lvl_first_valid", 64'(out_valid), 64'd1);
        chk("lvl_first_data",  64'(out_data),  64'(pk(12'hFFF, 12'h800, 12'h900, 12'h002)));
        chk("lvl_first_last",  64'(out_last),  64'd0);
        smp_data = pk(12'hFFF, 12'h801, 12'h900, 12'h003);
        tick();
        chk("lvl_second_data", 64'(out_data), 64'(pk(12'hFFF, 12'h801, 12'h900, 12'h003)));
        chk("lvl_second_last", 64'(out_last), 64'd1);
        chk("lvl_done",        64'(done),     64'd1);
        smp_valid = 0;

        // ---- external mode, post_len=0 (one sample)
        trig_mode = 2'b00; post_len = 16'd0; arm = 1;
        tick();
        arm = 0;
        chk("ext_arm_drain", 64'(out_valid), 64'd0);
        trig_ext = 1; smp_valid = 0;
        tick();
        chk("ext_no_strobe", 64'(out_valid), 64'd0);
        chk("ext_still_busy", 64'(busy), 64'd1);
        trig_ext = 0; smp_valid = 1; smp_data = rep(12'h0AA);
        tick();
        chk("ext_no_trig", 64'(out_valid), 64'd0);
        trig_ext = 1; smp_data = rep(12'h0BB);
        tick();
        chk("ext_valid", 64'(out_valid), 64'd1);
        chk("ext_data",  64'(out_data),  64'(rep(12'h0BB)));
        chk("ext_last",  64'(out_last),  64'd1);
        chk("ext_done",  64'(done),      64'd1);
        smp_data = rep(12'h0CC);
        tick();
        chk("ext_only_one", 64'(out_valid), 64'd0);
        trig_ext = 0; smp_valid = 0;

        // ---- backpressure: post_len=3, out_ready=0
        trig_mode = 2'b10; post_len = 16'd3; out_ready = 0; arm = 1;
        tick();
        arm = 0;
        smp_valid = 1; smp_data = rep(12'h101);
        tick();
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        chk("bp_no_ovf_yet",  64'(overflow),  64'd0);
        smp_data = rep(12'h102);
        tick();
        chk("bp_ovf",      64'(overflow), 64'd1);
        chk("bp_held",     64'(out_data), 64'(rep(12'h101)));
        chk("bp_busy",     64'(busy),     64'd1);
        smp_data = rep(12'h103);
        tick();
        chk("bp_done",     64'(done),     64'd1);
        chk("bp_held2",    64'(out_data), 64'(rep(12'h101)));
        chk("bp_last",     64'(out_last), 64'd0);
        chk("bp_ovf_held", 64'(overflow), 64'd1);
        smp_valid = 0; out_ready = 1;
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow), 64'd1);
        post_len = 16'd8; arm = 1;
        tick();
        arm = 0;
        chk("rearm_ovf_clr", 64'(overflow), 64'd0);
        chk("rearm_busy",    64'(busy),     64'd1);

        // ---- abort with simultaneous arm after 2 of 8 samples
        smp_valid = 1; smp_data = rep(12'h201);
        tick();
        smp_data = rep(12'h202);
        tick();
        chk("ab_pre_valid", 64'(out_valid), 64'd1);
        abort = 1; arm = 1; smp_data = rep(12'h203);
        tick();
        abort = 0; arm = 0;
        chk("ab_out_valid", 64'(out_valid), 64'd0);
        chk("ab_busy",      64'(busy),      64'd0);
        chk("ab_done",      64'(done),      64'd0);
        smp_data = rep(12'h204);
        tick();
        chk("ab_no_capture", 64'(out_valid), 64'd0);
        smp_valid = 0;

        // ---- async reset mid-capture
        arm = 1;
        tick();
        arm = 0;
        smp_valid = 1; smp_data = rep(12'h301);
        tick();
        smp_data = rep(12'h302);
        tick();
        chk("rc_pre_busy", 64'(busy), 64'd1);
        rst = 1;
        #1;
        chk("rc_out_valid", 64'(out_valid), 64'd0);
        chk("rc_out_data",  64'(out_data),  64'd0);
        chk("rc_busy",      64'(busy),      64'd0);
        chk("rc_done",      64'(done),      64'd0);
        chk("rc_tstamp",    64'(trig_tstamp), 64'd0);
        smp_valid = 0;
        tick();
        rst = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
